// File: rtl/exec_stage_mc.sv
// ARM execute stage: Val2 shifter, branch target, single-cycle ALU with NZCV flags,
// and an iterative shift-add MUL/MLA behind a valid/ready handshake with flush.
module exec_stage_mc #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MUL_STEP = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [3:0]        exe_cmd,
   input  logic              s_bit,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic              imm,
   input  logic [DATA_W-1:0] val_rn,
   input  logic [DATA_W-1:0] val_rm,
   input  logic [DATA_W-1:0] val_ra,
   input  logic [11:0]       shift_operand,
   input  logic [23:0]       signed_imm_24,
   input  logic [3:0]        sr,
   output logic              out_valid,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] br_addr,
   output logic [3:0]        status,
   output logic              status_we
);

   localparam int unsigned MSB     = DATA_W - 1;
   localparam int unsigned N_STEPS = DATA_W / MUL_STEP;
   localparam int unsigned CNT_W   = $clog2(N_STEPS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_STEPS - 1);

   localparam logic [3:0] OP_MOV = 4'b0001;
   localparam logic [3:0] OP_MVN = 4'b1001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_ADC = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SBC = 4'b0101;
   localparam logic [3:0] OP_AND = 4'b0110;
   localparam logic [3:0] OP_ORR = 4'b0111;
   localparam logic [3:0] OP_EOR = 4'b1000;
   localparam logic [3:0] OP_MUL = 4'b1010;
   localparam logic [3:0] OP_MLA = 4'b1011;

   typedef enum logic {IDLE, BUSY} state_t;
   state_t state_q, state_d;

   function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int unsigned amt);
      int unsigned a;
      a = amt % DATA_W;
      // a == 0 gives x << DATA_W == 0, so no special case is needed
      return (x >> a) | (x << (DATA_W - a));
   endfunction

   logic [DATA_W-1:0] val2, br_off, br_calc;
   logic [4:0]        sh_amt;

   assign sh_amt  = shift_operand[11:7];
   assign br_off  = DATA_W'({{DATA_W{signed_imm_24[23]}}, signed_imm_24, 2'b00});
   assign br_calc = pc_in + br_off;

   always_comb begin
      val2 = '0;
      if (mem_r_en || mem_w_en)
         val2 = DATA_W'(shift_operand);
      else if (imm)
         val2 = rotr(DATA_W'(shift_operand[7:0]), 32'(shift_operand[11:8]) * 2);
      else begin
         case (shift_operand[6:5])
            2'b00:   val2 = val_rm << sh_amt;
            2'b01:   val2 = val_rm >> sh_amt;
            2'b10:   val2 = $signed(val_rm) >>> sh_amt;
            default: val2 = rotr(val_rm, 32'(sh_amt));
         endcase
      end
   end

   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu_res;
   logic [3:0]        alu_flags;
   logic              c_new, v_new, flag_upd, arith_add, arith_sub, is_mul;

   assign is_mul = (exe_cmd == OP_MUL) || (exe_cmd == OP_MLA);

   always_comb begin
      sum       = '0;
      alu_res   = '0;
      c_new     = sr[1];
      v_new     = sr[0];
      flag_upd  = 1'b1;
      arith_add = 1'b0;
      arith_sub = 1'b0;
      case (exe_cmd)
         OP_MOV: alu_res = val2;
         OP_MVN: alu_res = ~val2;
         OP_ADD: begin sum = {1'b0, val_rn} + {1'b0, val2}; arith_add = 1'b1; end
         OP_ADC: begin sum = {1'b0, val_rn} + {1'b0, val2} + {{DATA_W{1'b0}}, sr[1]}; arith_add = 1'b1; end
         OP_SUB: begin sum = {1'b0, val_rn} + {1'b0, ~val2} + {{DATA_W{1'b0}}, 1'b1}; arith_sub = 1'b1; end
         OP_SBC: begin sum = {1'b0, val_rn} + {1'b0, ~val2} + {{DATA_W{1'b0}}, sr[1]}; arith_sub = 1'b1; end
         OP_AND: alu_res = val_rn & val2;
         OP_ORR: alu_res = val_rn | val2;
         OP_EOR: alu_res = val_rn ^ val2;
         default: flag_upd = 1'b0;
      endcase
      if (arith_add || arith_sub) begin
         alu_res = sum[MSB:0];
         c_new   = sum[DATA_W];
      end
      if (arith_add) v_new = (val_rn[MSB] == val2[MSB]) && (alu_res[MSB] != val_rn[MSB]);
      if (arith_sub) v_new = (val_rn[MSB] != val2[MSB]) && (alu_res[MSB] != val_rn[MSB]);
      alu_flags = flag_upd ? {alu_res[MSB], alu_res == '0, c_new, v_new} : sr;
   end

   logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, pp, mul_res, pend_br_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        pend_cv_q;
   logic              pend_s_q, accept, finish;

   always_comb begin
      pp = '0;
      for (int unsigned i = 0; i < MUL_STEP; i++)
         if (mplier_q[i]) pp = pp + (mcand_q << i);
      mul_res = acc_q + pp;
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      finish   = 1'b0;
      in_ready = (state_q == IDLE);
      case (state_q)
         IDLE: if (in_valid && !flush) begin
            accept = 1'b1;
            if (is_mul) state_d = BUSY;
         end
         BUSY: if (flush) state_d = IDLE;
               else if (cnt_q == LAST_CNT) begin
                  finish  = 1'b1;
                  state_d = IDLE;
               end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         status_we  <= 1'b0;
         alu_result <= '0;
         br_addr    <= '0;
         status     <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         pend_br_q  <= '0;
         pend_cv_q  <= '0;
         pend_s_q   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         status_we <= 1'b0;
         if (accept && !is_mul) begin
            out_valid  <= 1'b1;
            status_we  <= s_bit;
            alu_result <= alu_res;
            status     <= alu_flags;
            br_addr    <= br_calc;
         end
         // Multiply-side results wait in pend_* so the outputs hold until completion
         if (accept && is_mul) begin
            mcand_q   <= val_rn;
            mplier_q  <= val_rm;
            acc_q     <= (exe_cmd == OP_MLA) ? val_ra : '0;
            cnt_q     <= '0;
            pend_br_q <= br_calc;
            pend_cv_q <= sr[1:0];
            pend_s_q  <= s_bit;
         end
         if (state_q == BUSY) begin
            mcand_q  <= mcand_q << MUL_STEP;
            mplier_q <= mplier_q >> MUL_STEP;
            acc_q    <= mul_res;
            cnt_q    <= cnt_q + CNT_W'(1);
         end
         if (finish) begin
            out_valid  <= 1'b1;
            status_we  <= pend_s_q;
            alu_result <= mul_res;
            status     <= {mul_res[MSB], mul_res == '0, pend_cv_q};
            br_addr    <= pend_br_q;
         end
      end
   end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Bench for exec_stage_mc: directed checks plus randomized ops against an
// arithmetic reference model of Val2, ALU, flags, multiply and branch target.
module tb_exec_stage_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] pc_in = '0;
   logic [3:0]  exe_cmd = '0;
   logic        s_bit = 1'b0, mem_r_en = 1'b0, mem_w_en = 1'b0, imm = 1'b0;
   logic [31:0] val_rn = '0, val_rm = '0, val_ra = '0;
   logic [11:0] shift_operand = '0;
   logic [23:0] signed_imm_24 = '0;
   logic [3:0]  sr = '0;
   logic        out_valid;
   logic [31:0] alu_result, br_addr;
   logic [3:0]  status;
   logic        status_we;

   int total = 0;
   int bad   = 0;

   exec_stage_mc #(.DATA_W(32), .MUL_STEP(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .pc_in(pc_in), .exe_cmd(exe_cmd), .s_bit(s_bit), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .imm(imm), .val_rn(val_rn), .val_rm(val_rm), .val_ra(val_ra),
      .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .sr(sr),
      .out_valid(out_valid), .alu_result(alu_result), .br_addr(br_addr),
      .status(status), .status_we(status_we)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned r);
      if (r == 0) return x;
      return (x >> r) | (x << (32 - r));
   endfunction

   function automatic logic [31:0] m_val2(input logic memop, input logic im,
                                          input logic [11:0] so, input logic [31:0] rm);
      int unsigned r;
      if (memop) return {20'd0, so};
      if (im) return ror32({24'd0, so[7:0]}, 2 * so[11:8]);
      r = so[11:7];
      case (so[6:5])
         2'd0:    return rm << r;
         2'd1:    return rm >> r;
         2'd2:    return $signed(rm) >>> r;
         default: return ror32(rm, r);
      endcase
   endfunction

   function automatic logic ovf(input longint s);
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   task automatic ref_model(output logic [31:0] res, output logic [3:0] fl);
      logic [31:0] v2;
      logic c, v, known;
      longint unsigned u;
      longint a, b, ci;
      v2 = m_val2(mem_r_en | mem_w_en, imm, shift_operand, val_rm);
      a  = longint'($signed(val_rn));
      b  = longint'($signed(v2));
      ci = longint'(sr[1]);
      c = sr[1]; v = sr[0]; known = 1'b1; res = '0;
      case (exe_cmd)
         4'b0001: res = v2;
         4'b1001: res = ~v2;
         4'b0010: begin u = longint'(val_rn) + longint'(v2); res = u[31:0]; c = u[32]; v = ovf(a + b); end
         4'b0011: begin u = longint'(val_rn) + longint'(v2) + ci; res = u[31:0]; c = u[32]; v = ovf(a + b + ci); end
         4'b0100: begin res = val_rn - v2; c = (val_rn >= v2); v = ovf(a - b); end
         4'b0101: begin
            res = val_rn - v2 - 32'(!sr[1]);
            c = (longint'(val_rn) >= longint'(v2) + longint'(!sr[1]));
            v = ovf(a - b - longint'(!sr[1]));
         end
         4'b0110: res = val_rn & v2;
         4'b0111: res = val_rn | v2;
         4'b1000: res = val_rn ^ v2;
         4'b1010: res = val_rn * val_rm;
         4'b1011: res = val_rn * val_rm + val_ra;
         default: known = 1'b0;
      endcase
      fl = known ? {res[31], res == 32'd0, c, v} : sr;
   endtask

   function automatic logic [31:0] ref_br();
      int off;
      off = $signed(signed_imm_24);
      return pc_in + 32'(off * 4);
   endfunction

   task automatic set_op(input logic [3:0] cmd, input logic s, input logic mr, input logic mw,
                         input logic im, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [31:0] ra, input logic [11:0] so, input logic [23:0] off,
                         input logic [31:0] pc, input logic [3:0] f);
      exe_cmd = cmd; s_bit = s; mem_r_en = mr; mem_w_en = mw; imm = im;
      val_rn = rn; val_rm = rm; val_ra = ra; shift_operand = so;
      signed_imm_24 = off; pc_in = pc; sr = f;
   endtask

   task automatic run_op(input string tag);
      logic [31:0] e_res, e_br;
      logic [3:0]  e_fl;
      logic        e_we, rdy_err;
      int          lat, e_lat;
      ref_model(e_res, e_fl);
      e_br  = ref_br();
      e_we  = s_bit;
      e_lat = (exe_cmd == 4'b1010 || exe_cmd == 4'b1011) ? 32 : 0;
      check({tag, " rdy_in"}, in_ready, 1);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0; rdy_err = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_err = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " lat"}, lat, e_lat);
      check({tag, " busy_rdy"}, rdy_err, 0);
      check({tag, " ovalid"}, out_valid, 1);
      check({tag, " res"}, alu_result, e_res);
      check({tag, " status"}, status, e_fl);
      check({tag, " we"}, status_we, e_we);
      check({tag, " br"}, br_addr, e_br);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat, cnt, r;
      logic rdy_err;

      #1;
      check("rst ovalid", out_valid, 0);
      check("rst we", status_we, 0);
      check("rst res", alu_result, 0);
      check("rst br", br_addr, 0);
      check("rst status", status, 0);
      check("rst rdy", in_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      set_op(4'b0010, 1, 0, 0, 1, 32'h7FFF_FFFF, 0, 0, 12'h001, 0, 0, 4'b0000);
      run_op("add_ovf");
      check("add_ovf res_c", alu_result, 32'h8000_0000);
      check("add_ovf st_c", status, 4'b1001);

      set_op(4'b0100, 1, 0, 0, 0, 5, 5, 0, 12'h000, 0, 0, 4'b0000);
      run_op("sub_eq");
      check("sub_eq st_c", status, 4'b0110);
      set_op(4'b0100, 1, 0, 0, 0, 5, 6, 0, 12'h000, 0, 0, 4'b0000);
      run_op("sub_neg");
      check("sub_neg res_c", alu_result, 32'hFFFF_FFFF);
      check("sub_neg st_c", status, 4'b1000);

      set_op(4'b0001, 0, 0, 0, 1, 0, 0, 0, 12'h4FF, 0, 0, 4'b0000);
      run_op("v2_imm");
      check("v2_imm c", alu_result, 32'hFF00_0000);
      set_op(4'b0001, 0, 0, 0, 0, 0, 32'h8000_0000, 0, 12'h240, 0, 0, 4'b0000);
      run_op("v2_asr");
      check("v2_asr c", alu_result, 32'hF800_0000);
      set_op(4'b0010, 0, 0, 1, 0, 0, 32'h1234_5678, 0, 12'hFFF, 0, 0, 4'b0000);
      run_op("v2_str");
      check("v2_str c", alu_result, 32'h0000_0FFF);

      set_op(4'b0001, 0, 0, 0, 0, 0, 0, 0, 12'h000, 24'hFFFFFE, 32'h100, 4'b0000);
      run_op("br");
      check("br c", br_addr, 32'h0000_00F8);

      // MLA with an ADD held on in_valid throughout BUSY
      set_op(4'b1011, 1, 0, 0, 0, 3, 7, 10, 12'h000, 24'h000001, 32'h200, 4'b0011);
      in_valid = 1'b1;
      @(posedge clk); #1;
      set_op(4'b0010, 0, 0, 0, 1, 1, 0, 0, 12'h001, 0, 0, 4'b0000);
      lat = 0; rdy_err = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_err = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      check("mla lat", lat, 32);
      check("mla busy_rdy", rdy_err, 0);
      check("mla res", alu_result, 31);
      check("mla status", status, 4'b0011);
      check("mla we", status_we, 1);
      check("mla br", br_addr, 32'h204);
      check("mla rdy_end", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("held ovalid", out_valid, 1);
      check("held res", alu_result, 2);
      check("held we", status_we, 0);
      check("held status", status, 4'b0000);

      set_op(4'b1010, 1, 0, 0, 0, 5, 9, 0, 12'h000, 0, 0, 4'b0000);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush rdy", in_ready, 1);
      check("flush ovalid", out_valid, 0);
      cnt = 0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) cnt++; end
      check("flush no_ov", cnt, 0);
      check("flush hold", alu_result, 2);

      set_op(4'b0010, 1, 0, 0, 0, 100, 100, 0, 12'h000, 0, 0, 4'b0000);
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_idle ovalid", out_valid, 0);
      check("flush_idle hold", alu_result, 2);

      set_op(4'b1010, 1, 0, 0, 0, 5, 9, 0, 12'h000, 0, 0, 4'b0000);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      check("arst res", alu_result, 0);
      check("arst br", br_addr, 0);
      check("arst status", status, 0);
      check("arst ovalid", out_valid, 0);
      check("arst rdy", in_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      cnt = 0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) cnt++; end
      check("arst no_ov", cnt, 0);
      check("arst rdy2", in_ready, 1);

      for (int it = 0; it < 150; it++) begin
         r = $urandom_range(0, 3);
         set_op(4'($urandom_range(0, 15)), 1'($urandom), r == 1, r == 2, 1'($urandom),
                pick(), pick(), pick(), 12'($urandom), 24'($urandom), $urandom, 4'($urandom));
         run_op("rnd");
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
            check("rnd idle_ov", out_valid, 0);
            check("rnd idle_we", status_we, 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
